// File: rtl/rt_pkg.sv
// Shared types and fp32 constants for the camera ray generator and its adder.
package rt_pkg;

  localparam int FP32_SIGN_W = 1;
  localparam int FP32_EXP_W  = 8;
  localparam int FP32_MAN_W  = 23;

  localparam logic [31:0] FP32_POS_ZERO = 32'h0000_0000;
  localparam logic [31:0] FP32_MAX      = 32'h7F7F_FFFF;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_EMIT  = 3'd3,
    ST_STEP  = 3'd4
  } state_e;

endpackage

// File: rtl/fp32_add.sv
// Combinational fp32 adder: round-to-nearest-even, denormals flushed to +0,
// overflow saturates to signed infinity. NaN inputs are not supported.
module fp32_add
  import rt_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] sum
);

  localparam logic [FP32_EXP_W-1:0] EXP_MAX = '1;

  logic                  a_zero, b_zero, a_inf, b_inf, a_ge;
  logic [31:0]           big, sml;
  logic [FP32_EXP_W-1:0] d;
  logic [49:0]           sml_full, sml_sh;
  logic [26:0]           big_x, sml_x, norm;
  logic [27:0]           raw;
  logic [4:0]            lz;
  logic                  found, round_up;
  logic signed [9:0]     exp_n;
  logic [24:0]           mant_r;
  logic [FP32_MAN_W-1:0] frac;

  always_comb begin
    a_zero = (a[30:23] == '0);
    b_zero = (b[30:23] == '0);
    a_inf  = (a[30:23] == EXP_MAX);
    b_inf  = (b[30:23] == EXP_MAX);
    a_ge   = (a[30:0] >= b[30:0]);
    big    = a_ge ? a : b;
    sml    = a_ge ? b : a;
    d      = big[30:23] - sml[30:23];

    // Align the smaller operand, folding everything shifted out into a sticky bit.
    sml_full = {1'b1, sml[22:0], 26'b0};
    sml_sh   = sml_full >> d;
    sml_x    = {sml_sh[49:24], |sml_sh[23:0]};
    big_x    = {1'b1, big[22:0], 3'b000};
    raw      = (big[31] ^ sml[31]) ? ({1'b0, big_x} - {1'b0, sml_x})
                                   : ({1'b0, big_x} + {1'b0, sml_x});

    lz    = '0;
    found = 1'b0;
    for (int i = 26; i >= 0; i--) begin
      if (!found && raw[i]) begin
        lz    = 5'(26 - i);
        found = 1'b1;
      end
    end

    if (raw[27]) begin
      norm  = {raw[27:2], raw[1] | raw[0]};
      exp_n = $signed({2'b00, big[30:23]}) + 10'sd1;
    end else begin
      norm  = raw[26:0] << lz;
      exp_n = $signed({2'b00, big[30:23]}) - $signed({5'b00000, lz});
    end

    round_up = norm[2] & ((|norm[1:0]) | norm[3]);
    mant_r   = {1'b0, norm[26:3]} + {24'b0, round_up};
    if (mant_r[24]) begin
      exp_n = exp_n + 10'sd1;
      frac  = mant_r[23:1];
    end else begin
      frac  = mant_r[22:0];
    end

    if (a_inf)                sum = a;
    else if (b_inf)           sum = b;
    else if (a_zero && b_zero) sum = FP32_POS_ZERO;
    else if (a_zero)          sum = b;
    else if (b_zero)          sum = a;
    else if (raw == '0)       sum = FP32_POS_ZERO;
    else if (exp_n <= 10'sd0) sum = FP32_POS_ZERO;
    else if (exp_n >= 10'sd255) sum = {big[31], EXP_MAX, {FP32_MAN_W{1'b0}}};
    else                      sum = {big[31], exp_n[7:0], frac};
  end

endmodule

// File: rtl/ray_gen.sv
// Row-major camera ray generator: issues one ray per pixel to rtunit and
// forwards each hit record downstream on a ready/valid stream.
//
// state    | meaning
// IDLE     | waiting for start, config latched on accept
// ISSUE    | rt_valid pulse for the current pixel
// WAIT     | waiting for rt_done, results captured on it
// EMIT     | px record presented until downstream accepts
// STEP     | advance column/row and accumulate direction
module ray_gen
  import rt_pkg::*;
#(
  parameter int WIDTH  = 100,
  parameter int HEIGHT = 100
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] origin_x,
  input  logic [31:0] origin_y,
  input  logic [31:0] origin_z,
  input  logic [31:0] dir0_x,
  input  logic [31:0] dir0_y,
  input  logic [31:0] dir_z,
  input  logic [31:0] step_x,
  input  logic [31:0] step_y,
  input  logic [31:0] tmax,
  output logic        busy,
  output logic        frame_done,
  output logic        rt_valid,
  output logic [31:0] rt_origin_x,
  output logic [31:0] rt_origin_y,
  output logic [31:0] rt_origin_z,
  output logic [31:0] rt_dir_x,
  output logic [31:0] rt_dir_y,
  output logic [31:0] rt_dir_z,
  output logic [31:0] rt_tmax,
  input  logic        rt_done,
  input  logic        rt_intersected,
  input  logic [31:0] rt_t,
  input  logic [31:0] rt_u,
  input  logic [31:0] rt_v,
  input  logic [31:0] rt_n_x,
  input  logic [31:0] rt_n_y,
  input  logic [31:0] rt_n_z,
  output logic        px_valid,
  input  logic        px_ready,
  output logic [15:0] px_x,
  output logic [15:0] px_y,
  output logic        px_hit,
  output logic [31:0] px_t,
  output logic [31:0] px_u,
  output logic [31:0] px_v,
  output logic [31:0] px_n_x,
  output logic [31:0] px_n_y,
  output logic [31:0] px_n_z
);

  localparam logic [15:0] LAST_COL = 16'(WIDTH - 1);
  localparam logic [15:0] LAST_ROW = 16'(HEIGHT - 1);

  state_e      state;
  logic [31:0] dir0_x_q, step_x_q, step_y_q;
  logic [31:0] cur_dx, cur_dy;
  logic [31:0] add_a, add_b, add_sum;
  logic        row_end;

  assign row_end     = (px_x == LAST_COL);
  assign rt_valid    = (state == ST_ISSUE);
  assign px_valid    = (state == ST_EMIT);
  assign rt_dir_x    = cur_dx;
  assign rt_dir_y    = cur_dy;

  // One adder serves both accumulators; STEP only ever updates one of them.
  assign add_a = row_end ? cur_dy   : cur_dx;
  assign add_b = row_end ? step_y_q : step_x_q;

  fp32_add u_add (
    .a   (add_a),
    .b   (add_b),
    .sum (add_sum)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= ST_IDLE;
      busy        <= 1'b0;
      frame_done  <= 1'b0;
      rt_origin_x <= FP32_POS_ZERO;
      rt_origin_y <= FP32_POS_ZERO;
      rt_origin_z <= FP32_POS_ZERO;
      rt_dir_z    <= FP32_POS_ZERO;
      rt_tmax     <= FP32_POS_ZERO;
      dir0_x_q    <= FP32_POS_ZERO;
      step_x_q    <= FP32_POS_ZERO;
      step_y_q    <= FP32_POS_ZERO;
      cur_dx      <= FP32_POS_ZERO;
      cur_dy      <= FP32_POS_ZERO;
      px_x        <= '0;
      px_y        <= '0;
      px_hit      <= 1'b0;
      px_t        <= '0;
      px_u        <= '0;
      px_v        <= '0;
      px_n_x      <= '0;
      px_n_y      <= '0;
      px_n_z      <= '0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            rt_origin_x <= origin_x;
            rt_origin_y <= origin_y;
            rt_origin_z <= origin_z;
            rt_dir_z    <= dir_z;
            rt_tmax     <= tmax;
            dir0_x_q    <= dir0_x;
            step_x_q    <= step_x;
            step_y_q    <= step_y;
            cur_dx      <= dir0_x;
            cur_dy      <= dir0_y;
            px_x        <= '0;
            px_y        <= '0;
            busy        <= 1'b1;
            state       <= ST_ISSUE;
          end
        end
        ST_ISSUE: state <= ST_WAIT;
        ST_WAIT: begin
          if (rt_done) begin
            px_hit <= rt_intersected;
            px_t   <= rt_t;
            px_u   <= rt_u;
            px_v   <= rt_v;
            px_n_x <= rt_n_x;
            px_n_y <= rt_n_y;
            px_n_z <= rt_n_z;
            state  <= ST_EMIT;
          end
        end
        ST_EMIT: begin
          if (px_ready) begin
            if (row_end && px_y == LAST_ROW) begin
              busy       <= 1'b0;
              frame_done <= 1'b1;
              state      <= ST_IDLE;
            end else begin
              state <= ST_STEP;
            end
          end
        end
        ST_STEP: begin
          if (row_end) begin
            px_x   <= '0;
            px_y   <= px_y + 16'd1;
            cur_dx <= dir0_x_q;
            cur_dy <= add_sum;
          end else begin
            px_x   <= px_x + 16'd1;
            cur_dx <= add_sum;
          end
          state <= ST_ISSUE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ray_gen.sv
// Scoreboard bench for ray_gen on a 2x2 frame with a fixed-latency rtunit model.
module tb_ray_gen;

  localparam int W = 2;
  localparam int H = 2;

  typedef struct {
    logic [15:0] x, y;
    logic        hit;
    logic [31:0] t, u, nz;
  } rec_t;

  typedef struct {
    logic [31:0] dx, dy;
  } ray_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [31:0] origin_x = 32'h3F00_0000, origin_y = 32'hBF00_0000, origin_z = 32'h4120_0000;
  logic [31:0] dir0_x = 32'h3DCC_CCCD, dir0_y = 32'h3DCC_CCCD, dir_z = 32'hBF80_0000;
  logic [31:0] step_x = 32'hBDCC_CCCD, step_y = 32'hBDCC_CCCD, tmax = 32'h7F7F_FFFF;
  logic        busy, frame_done, rt_valid, rt_done, rt_intersected;
  logic [31:0] rt_origin_x, rt_origin_y, rt_origin_z, rt_dir_x, rt_dir_y, rt_dir_z, rt_tmax;
  logic [31:0] rt_t, rt_u, rt_v, rt_n_x, rt_n_y, rt_n_z;
  logic        px_valid, px_ready = 1'b1, px_hit;
  logic [15:0] px_x, px_y;
  logic [31:0] px_t, px_u, px_v, px_n_x, px_n_y, px_n_z;

  logic [31:0] fa = '0, fb = '0, fs;

  always #5 clk = ~clk;

  ray_gen #(.WIDTH(W), .HEIGHT(H)) dut (
    .clk(clk), .reset(reset), .start(start),
    .origin_x(origin_x), .origin_y(origin_y), .origin_z(origin_z),
    .dir0_x(dir0_x), .dir0_y(dir0_y), .dir_z(dir_z),
    .step_x(step_x), .step_y(step_y), .tmax(tmax),
    .busy(busy), .frame_done(frame_done), .rt_valid(rt_valid),
    .rt_origin_x(rt_origin_x), .rt_origin_y(rt_origin_y), .rt_origin_z(rt_origin_z),
    .rt_dir_x(rt_dir_x), .rt_dir_y(rt_dir_y), .rt_dir_z(rt_dir_z), .rt_tmax(rt_tmax),
    .rt_done(rt_done), .rt_intersected(rt_intersected),
    .rt_t(rt_t), .rt_u(rt_u), .rt_v(rt_v),
    .rt_n_x(rt_n_x), .rt_n_y(rt_n_y), .rt_n_z(rt_n_z),
    .px_valid(px_valid), .px_ready(px_ready), .px_x(px_x), .px_y(px_y), .px_hit(px_hit),
    .px_t(px_t), .px_u(px_u), .px_v(px_v),
    .px_n_x(px_n_x), .px_n_y(px_n_y), .px_n_z(px_n_z)
  );

  fp32_add u_fadd (.a(fa), .b(fb), .sum(fs));

  int n_tests = 0;
  int n_fail  = 0;
  int fd_cnt  = 0;
  rec_t exp_q[$];
  ray_t ray_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // rtunit model: done pulse 3 cycles after each valid, hit data per pixel index
  logic [31:0] t_tbl [4] = '{32'h4000_0000, 32'h3F80_0000, 32'h4040_0000, 32'h4080_0000};
  logic        hit_tbl [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
  int          m_cnt = 0;
  int          m_idx = 0;
  logic [1:0]  m_cur = '0;
  logic        model_done = 1'b0;
  logic        inj_done = 1'b0;

  always @(posedge clk) begin
    if (!reset) begin
      m_cnt      <= 0;
      m_idx      <= 0;
      model_done <= 1'b0;
    end else begin
      model_done <= (m_cnt == 1);
      if (rt_valid) begin
        m_cnt <= 2;
        m_cur <= m_idx[1:0];
        m_idx <= m_idx + 1;
      end else if (m_cnt != 0) begin
        m_cnt <= m_cnt - 1;
      end
    end
  end

  assign rt_done        = model_done | inj_done;
  assign rt_intersected = hit_tbl[m_cur];
  assign rt_t           = t_tbl[m_cur];
  assign rt_u           = t_tbl[m_cur] + 32'd1;
  assign rt_v           = t_tbl[m_cur] + 32'd2;
  assign rt_n_x         = t_tbl[m_cur] + 32'd3;
  assign rt_n_y         = t_tbl[m_cur] + 32'd4;
  assign rt_n_z         = t_tbl[m_cur] + 32'd5;

  // Ray monitor
  always @(negedge clk) begin
    if (reset && rt_valid) begin
      if (ray_q.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL ray_extra: got dir_x %h expected no ray", rt_dir_x);
      end else begin
        ray_t r;
        r = ray_q.pop_front();
        check("rt_dir_x", rt_dir_x, r.dx);
        check("rt_dir_y", rt_dir_y, r.dy);
        check("rt_dir_z", rt_dir_z, 32'hBF80_0000);
        check("rt_origin_z", rt_origin_z, 32'h4120_0000);
        check("rt_tmax", rt_tmax, 32'h7F7F_FFFF);
      end
    end
  end

  // Pixel record monitor
  always @(negedge clk) begin
    if (reset && frame_done) fd_cnt++;
    if (reset && px_valid && px_ready) begin
      if (exp_q.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL px_extra: got (%0d,%0d) expected no record", px_x, px_y);
      end else begin
        rec_t e;
        e = exp_q.pop_front();
        check("px_x", {16'b0, px_x}, {16'b0, e.x});
        check("px_y", {16'b0, px_y}, {16'b0, e.y});
        check("px_hit", {31'b0, px_hit}, {31'b0, e.hit});
        check("px_t", px_t, e.t);
        check("px_u", px_u, e.u);
        check("px_n_z", px_n_z, e.nz);
      end
    end
  end

  task automatic push_frame();
    for (int k = 0; k < W * H; k++) begin
      rec_t e;
      ray_t r;
      e.x   = 16'(k % W);
      e.y   = 16'(k / W);
      e.hit = hit_tbl[k];
      e.t   = t_tbl[k];
      e.u   = t_tbl[k] + 32'd1;
      e.nz  = t_tbl[k] + 32'd5;
      exp_q.push_back(e);
      r.dx = (k % W == 0) ? 32'h3DCC_CCCD : 32'h0000_0000;
      r.dy = (k / W == 0) ? 32'h3DCC_CCCD : 32'h0000_0000;
      ray_q.push_back(r);
    end
  endtask

  task automatic start_frame(input string name);
    push_frame();
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check({name, "_rt_valid_c1"}, {31'b0, rt_valid}, 32'd1);
    check({name, "_busy"}, {31'b0, busy}, 32'd1);
  endtask

  task automatic wait_frame(input string name);
    bit seen;
    seen = 1'b0;
    for (int c = 0; c < 300 && !seen; c++) begin
      @(negedge clk);
      if (frame_done) seen = 1'b1;
    end
    n_tests++;
    if (!seen) begin
      n_fail++;
      $display("FAIL %s_timeout: got no frame_done expected one within 300 cycles", name);
    end else begin
      check({name, "_busy_low"}, {31'b0, busy}, 32'd0);
      @(negedge clk);
      check({name, "_fd_pulse"}, {31'b0, frame_done}, 32'd0);
    end
    check({name, "_exp_left"}, 32'(exp_q.size()), 32'd0);
    check({name, "_ray_left"}, 32'(ray_q.size()), 32'd0);
  endtask

  task automatic check_zero(input string name);
    logic any;
    any = busy | frame_done | rt_valid | px_valid | px_hit | (|px_x) | (|px_y)
        | (|rt_origin_x) | (|rt_origin_y) | (|rt_origin_z) | (|rt_dir_x) | (|rt_dir_y)
        | (|rt_dir_z) | (|rt_tmax) | (|px_t) | (|px_u) | (|px_v)
        | (|px_n_x) | (|px_n_y) | (|px_n_z);
    check(name, {31'b0, any}, 32'd0);
  endtask

  task automatic add_vec(input logic [31:0] a, input logic [31:0] b, input logic [31:0] s);
    fa = a;
    fb = b;
    #1;
    check("fp32_add", fs, s);
  endtask

  initial begin
    logic [15:0] hx, hy;
    logic [31:0] ht;
    bit          got;

    repeat (3) @(posedge clk);
    #1;
    check_zero("reset_outputs");
    reset = 1'b1;

    // Frame 1: free-running downstream
    start_frame("f1");
    wait_frame("f1");
    check("f1_fd_count", 32'(fd_cnt), 32'd1);

    // Frame 2: stalled downstream, stray start in WAIT, stray rt_done in EMIT
    px_ready = 1'b0;
    start_frame("f2");
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    got = 1'b0;
    for (int c = 0; c < 20 && !got; c++) begin
      if (px_valid) got = 1'b1;
      else begin @(posedge clk); #1; end
    end
    check("f2_emit_reached", {31'b0, got}, 32'd1);
    hx = px_x; hy = px_y; ht = px_t;
    check("f2_first_x", {16'b0, hx}, 32'd0);
    inj_done = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      inj_done = 1'b0;
      check("stall_valid", {31'b0, px_valid}, 32'd1);
      check("stall_rt_valid", {31'b0, rt_valid}, 32'd0);
      check("stall_hold", {px_x, px_y} ^ {hx, hy} | (px_t ^ ht), 32'd0);
    end
    px_ready = 1'b1;
    @(posedge clk); #1;
    check("resume_step", {31'b0, px_valid | rt_valid}, 32'd0);
    @(posedge clk); #1;
    check("resume_issue", {31'b0, rt_valid}, 32'd1);
    wait_frame("f2");
    check("f2_fd_count", 32'(fd_cnt), 32'd2);

    // Frame 3: reset mid-frame, then a clean frame from (0,0)
    push_frame();
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    reset = 1'b0;
    exp_q.delete();
    ray_q.delete();
    repeat (5) @(posedge clk);
    #1;
    check_zero("midframe_reset");
    reset = 1'b1;
    start_frame("f3");
    wait_frame("f3");
    check("f3_fd_count", 32'(fd_cnt), 32'd3);

    add_vec(32'h3F80_0000, 32'h3F80_0000, 32'h4000_0000);
    add_vec(32'h3F80_0000, 32'hBF80_0000, 32'h0000_0000);
    add_vec(32'h0000_0001, 32'h0000_0000, 32'h0000_0000);
    add_vec(32'h7F7F_FFFF, 32'h7F7F_FFFF, 32'h7F80_0000);
    add_vec(32'h3DCC_CCCD, 32'hBDCC_CCCD, 32'h0000_0000);
    add_vec(32'h3F80_0000, 32'h4000_0000, 32'h4040_0000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
